// File: rtl/upper_seq_buffer.sv
// Merge-sort upper-layer batch buffer: fills up to TRAIN_LENGTH multi-lane entries, then drains head-first, optionally sentinel-padded.
// One turnaround cycle from the closing accept to out_valid; input is refused while draining, the drain holds on out_ready low.
module upper_seq_buffer #(
  parameter int TRAIN_LENGTH = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CH       = 2,
  parameter int PAD_OUT      = 1,
  localparam int W  = NUM_CH * DATA_WIDTH,
  localparam int CW = $clog2(TRAIN_LENGTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  localparam logic [W-1:0]  SENT  = {W{1'b1}};
  localparam logic [CW-1:0] TL_C  = CW'(TRAIN_LENGTH);
  localparam logic [CW-1:0] TL_M1 = CW'(TRAIN_LENGTH - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  state_t        state, state_nxt;
  logic [W-1:0]  slot [TRAIN_LENGTH];
  logic [CW-1:0] beat;
  logic          primed;
  logic          accept, pop;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign full   = (count == TL_C);
  assign empty  = (count == '0);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    case (state)
      IDLE, FILL: begin
        in_ready = reset && !flush;
        if (in_valid && in_ready)
          state_nxt = (in_last || count == TL_M1) ? DRAIN : FILL;
      end
      DRAIN: begin
        out_valid = primed && !flush;
        // Once the real entries are gone the head reads as sentinel, whatever the slot holds.
        out_data  = (count != '0) ? slot[0] : SENT;
        out_last  = primed && ((PAD_OUT != 0) ? (beat == TL_M1) : (count == ONE));
        if (out_valid && out_ready && out_last)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      beat   <= '0;
      primed <= 1'b0;
      for (int i = 0; i < TRAIN_LENGTH; i++)
        slot[i] <= '0;
    end else if (flush) begin
      state  <= IDLE;
      count  <= '0;
      beat   <= '0;
      primed <= 1'b0;
      for (int i = 0; i < TRAIN_LENGTH; i++)
        slot[i] <= SENT;
    end else begin
      state  <= state_nxt;
      primed <= (state == DRAIN) && (state_nxt == DRAIN);
      if (accept) begin
        for (int i = 0; i < TRAIN_LENGTH; i++)
          if (count == CW'(i))
            slot[i] <= in_data;
        count <= count + 1'b1;
      end
      if (pop) begin
        if (out_last) begin
          count <= '0;
          beat  <= '0;
          for (int i = 0; i < TRAIN_LENGTH; i++)
            slot[i] <= SENT;
        end else begin
          for (int i = 0; i < TRAIN_LENGTH - 1; i++)
            slot[i] <= slot[i+1];
          slot[TRAIN_LENGTH-1] <= SENT;
          if (count != '0)
            count <= count - 1'b1;
          beat <= beat + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_upper_seq_buffer.sv
// Scoreboard bench: a padded and an unpadded instance share stimulus; expected drain beats are queued per batch and checked by monitors.
module tb_upper_seq_buffer;
  localparam int TL = 3;
  localparam int DW = 8;
  localparam int NC = 2;
  localparam int W  = NC * DW;
  localparam int CW = $clog2(TL + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, in_valid, in_last, out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready1, out_valid1, out_last1, full1, empty1;
  logic          in_ready0, out_valid0, out_last0, full0, empty0;
  logic [W-1:0]  out_data1, out_data0;
  logic [CW-1:0] count1, count0;

  upper_seq_buffer #(.TRAIN_LENGTH(TL), .DATA_WIDTH(DW), .NUM_CH(NC), .PAD_OUT(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_last(out_last1),
    .count(count1), .full(full1), .empty(empty1));

  upper_seq_buffer #(.TRAIN_LENGTH(TL), .DATA_WIDTH(DW), .NUM_CH(NC), .PAD_OUT(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_last(out_last0),
    .count(count0), .full(full0), .empty(empty0));

  typedef struct packed {
    logic [W-1:0]  data;
    logic          last;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t         q1[$];
  exp_t         q0[$];
  logic [W-1:0] stim[$];
  int           checks   = 0;
  int           failures = 0;
  int           rdy_mode = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // out_ready: 0 random throttle, 1 always ready, 2 stalled
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (q1.size() == 0) chk("p1_spurious_valid", out_valid1, 0);
    else if (out_valid1) begin
      chk("p1_beat_data", out_data1, q1[0].data);
      chk("p1_beat_last", out_last1, q1[0].last);
      chk("p1_beat_count", count1, q1[0].cnt);
      chk("p1_drain_in_ready", in_ready1, 0);
      if (out_ready) void'(q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (q0.size() == 0) chk("p0_spurious_valid", out_valid0, 0);
    else if (out_valid0) begin
      chk("p0_beat_data", out_data0, q0[0].data);
      chk("p0_beat_last", out_last0, q0[0].last);
      chk("p0_beat_count", count0, q0[0].cnt);
      chk("p0_drain_in_ready", in_ready0, 0);
      if (out_ready) void'(q0.pop_front());
    end
  end

  // Reference drain: padded instance always emits TL beats, unpadded emits the real entries only.
  task automatic push_expected(input int n);
    exp_t e;
    for (int j = 0; j < TL; j++) begin
      e.data = (j < n) ? stim[j] : {W{1'b1}};
      e.last = (j == TL - 1);
      e.cnt  = (j < n) ? CW'(n - j) : '0;
      q1.push_back(e);
    end
    for (int j = 0; j < n; j++) begin
      e.data = stim[j];
      e.last = (j == n - 1);
      e.cnt  = CW'(n - j);
      q0.push_back(e);
    end
  endtask

  task automatic send_batch(input bit use_last);
    int n;
    n = stim.size();
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = stim[k];
      in_last  = use_last && (k == n - 1);
      @(negedge clk);
      chk("fill_in_ready_p1", in_ready1, 1);
      chk("fill_in_ready_p0", in_ready0, 1);
      chk("fill_count_p1", count1, k);
      chk("fill_count_p0", count0, k);
      chk("fill_empty_p1", empty1, k == 0);
      chk("fill_full_p1", full1, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (use_last || n == TL) begin
      push_expected(n);
      @(negedge clk);
      chk("turnaround_valid_p1", out_valid1, 0);
      chk("turnaround_valid_p0", out_valid0, 0);
      chk("closed_in_ready_p1", in_ready1, 0);
      chk("closed_in_ready_p0", in_ready0, 0);
      chk("closed_full_p1", full1, n == TL);
      chk("closed_count_p0", count0, n);
      @(negedge clk);
      chk("first_beat_valid_p1", out_valid1, 1);
      chk("first_beat_valid_p0", out_valid0, 1);
    end
  endtask

  task automatic wait_drained();
    int t;
    t = 0;
    while ((q1.size() != 0 || q0.size() != 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    checks++;
    if (t >= 200) begin
      failures++;
      $display("FAIL drain_timeout: actual=%0d beats pending required=0", q1.size() + q0.size());
      q1.delete();
      q0.delete();
    end
    @(negedge clk);
    chk("idle_empty_p1", empty1, 1);
    chk("idle_empty_p0", empty0, 1);
    chk("idle_count_p1", count1, 0);
    chk("idle_in_ready_p1", in_ready1, 1);
    chk("idle_in_ready_p0", in_ready0, 1);
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready_p1", in_ready1, 0);
    chk("rst_in_ready_p0", in_ready0, 0);
    chk("rst_out_valid_p1", out_valid1, 0);
    chk("rst_out_last_p1", out_last1, 0);
    chk("rst_out_data_p1", out_data1, 0);
    chk("rst_out_data_p0", out_data0, 0);
    chk("rst_count_p1", count1, 0);
    chk("rst_count_p0", count0, 0);
    chk("rst_full_p1", full1, 0);
    chk("rst_empty_p1", empty1, 1);
    chk("rst_empty_p0", empty0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_values();
    @(negedge clk) reset = 1'b1;

    // three-entry batch closed by in_last, consumer always ready
    rdy_mode = 1;
    stim = '{16'h0A05, 16'h0703, 16'h0109};
    send_batch(1'b1);
    wait_drained();

    // single entry: padded to three beats on one instance, one beat on the other
    rdy_mode = 0;
    stim = '{16'h2211};
    send_batch(1'b1);
    wait_drained();

    // fill to capacity without in_last, then hold extra input while the drain is stalled
    rdy_mode = 2;
    stim = '{16'h1357, 16'h2468, 16'h0F0E};
    send_batch(1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 16'h4444;
      in_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("over_in_ready_p1", in_ready1, 0);
      chk("over_in_ready_p0", in_ready0, 0);
      chk("over_full_p1", full1, 1);
      chk("over_count_p0", count0, TL);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    rdy_mode = 0;
    wait_drained();

    for (int b = 0; b < 30; b++) begin
      int n;
      bit ul;
      n  = $urandom_range(1, TL);
      ul = (n < TL) ? 1'b1 : 1'($urandom_range(0, 1));
      stim.delete();
      for (int k = 0; k < n; k++) stim.push_back(W'($urandom));
      rdy_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      send_batch(ul);
      wait_drained();
    end

    // asynchronous reset after the first pop of a drain
    rdy_mode = 1;
    stim = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
    send_batch(1'b1);
    begin
      int t;
      t = 0;
      while (q1.size() == TL && t < 50) begin
        @(posedge clk);
        t++;
      end
      checks++;
      if (t >= 50) begin
        failures++;
        $display("FAIL first_pop_timeout: actual=%0d pending required=%0d", q1.size(), TL - 1);
      end
    end
    #1 reset = 1'b0;
    #1 check_reset_values();
    q1.delete();
    q0.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // flush with two entries held, then a short batch must not expose the flushed data
    stim = '{16'h5A5A, 16'h6B6B};
    send_batch(1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready_p1", in_ready1, 0);
    chk("flush_in_ready_p0", in_ready0, 0);
    chk("flush_out_valid_p1", out_valid1, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("post_flush_count_p1", count1, 0);
    chk("post_flush_count_p0", count0, 0);
    chk("post_flush_empty_p1", empty1, 1);
    rdy_mode = 0;
    stim = '{16'h7C7C};
    send_batch(1'b1);
    wait_drained();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
